// File: rtl/compression_frame_buffer.sv
// compression_frame_buffer
//   Single-clock output FIFO between the compression core and the AHB slave.
//   Tracks frame boundaries (one-cycle frame_done pulse, saturating count of
//   complete frames not yet read), flags write overflow, supports a
//   non-power-of-two depth and a synchronous flush (soft_clr).
//
// Optional feature macro: COMP_BUF_WATERMARK_EN
//   defined   : almost_full = (level >= AFULL_THRESH)
//   undefined : almost_full tied to 0, AFULL_THRESH ignored
//
// Ports
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready   push side; push when wr_valid && wr_ready
//   rd_req          pop request; rd_data/rd_valid registered one cycle later
//   soft_clr        synchronous flush, priority over push/pop
//   level/full/empty/almost_full   occupancy status
//   frame_done      pulse after the last word of a frame is accepted
//   frames_pending  complete frames written but not fully read (sat. 15)
//   overflow_err    sticky, set by wr_valid while full

module compression_frame_buffer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned FRAME_WORDS  = 3584,
    parameter int unsigned AFULL_THRESH = 4080,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  soft_clr,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  frame_done,
    output logic [3:0]            frames_pending,
    output logic                  overflow_err
);

    localparam int unsigned FCW = $clog2(FRAME_WORDS);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [FCW-1:0]        wr_frame_cnt;
    logic [FCW-1:0]        rd_frame_cnt;
    logic                  push;
    logic                  pop;
    logic                  wr_frame_end;
    logic                  rd_frame_end;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign wr_ready = !full && !soft_clr;

    // Pop is qualified by the registered empty flag only, so a same-cycle
    // push never falls through to the read side.
    assign push = wr_valid && wr_ready;
    assign pop  = rd_req && !empty && !soft_clr;

    assign wr_frame_end = push && (wr_frame_cnt == FCW'(FRAME_WORDS - 1));
    assign rd_frame_end = pop  && (rd_frame_cnt == FCW'(FRAME_WORDS - 1));

`ifdef COMP_BUF_WATERMARK_EN
    if (AFULL_THRESH == 0 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("AFULL_THRESH must be in 1..DEPTH");
    end
    assign almost_full = (level >= LW'(AFULL_THRESH));
`else
    localparam int unsigned unused_afull_thresh = AFULL_THRESH;
    assign almost_full = 1'b0;
`endif

    // Storage is not reset.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            wr_frame_cnt   <= '0;
            rd_frame_cnt   <= '0;
            frames_pending <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            frame_done     <= 1'b0;
            overflow_err   <= 1'b0;
        end else if (soft_clr) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            wr_frame_cnt   <= '0;
            rd_frame_cnt   <= '0;
            frames_pending <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            frame_done     <= 1'b0;
            overflow_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr       <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
                wr_frame_cnt <= wr_frame_end ? '0 : wr_frame_cnt + FCW'(1);
            end
            if (pop) begin
                rd_ptr       <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
                rd_frame_cnt <= rd_frame_end ? '0 : rd_frame_cnt + FCW'(1);
                rd_data      <= mem[rd_ptr];
            end
            rd_valid   <= pop;
            frame_done <= wr_frame_end;

            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (wr_valid && full) begin
                overflow_err <= 1'b1;
            end

            // Saturates at 15 and floors at 0; simultaneous inc/dec cancel.
            if (wr_frame_end && !rd_frame_end) begin
                if (frames_pending != 4'd15) begin
                    frames_pending <= frames_pending + 4'd1;
                end
            end else if (rd_frame_end && !wr_frame_end) begin
                if (frames_pending != 4'd0) begin
                    frames_pending <= frames_pending - 4'd1;
                end
            end
        end
    end

endmodule
